// File: rtl/pixel_pkg.sv
// Shared constants, FSM state encoding and the (x,y)->linear address helper
// for the pixel plotter.
package pixel_pkg;

   localparam int unsigned FB_W       = 160;
   localparam int unsigned FB_H       = 120;
   localparam int unsigned COORD_W    = 8;
   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned COLOR_W    = 3;
   localparam int unsigned FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FINISH
   } plot_state_t;

   function automatic int unsigned xy_to_addr(input int unsigned x,
                                              input int unsigned y,
                                              input int unsigned fb_w);
      // 160 = 128 + 32: the row multiply collapses to two shifts and an add
      if (fb_w == 160) return (y << 7) + (y << 5) + x;
      return y * fb_w + x;
   endfunction

endpackage

// File: rtl/pixel_plotter_if.sv
// Pixel stream (rasterizer -> plotter) and video RAM write port (plotter ->
// memory). The plotter uses the slave modport; the environment uses master.
interface pixel_plotter_if #(
   parameter int unsigned COORD_W = pixel_pkg::COORD_W,
   parameter int unsigned ADDR_W  = pixel_pkg::ADDR_W,
   parameter int unsigned COLOR_W = pixel_pkg::COLOR_W
);

   logic               PIX_VALID;
   logic               PIX_READY;
   logic [COORD_W-1:0] X_IN;
   logic [COORD_W-1:0] Y_IN;
   logic               LINE_DONE;
   logic               MEM_REQ;
   logic               MEM_ACK;
   logic [ADDR_W-1:0]  MEM_ADDR;
   logic [COLOR_W-1:0] MEM_DATA;

   modport slave (
      input  PIX_VALID, X_IN, Y_IN, LINE_DONE, MEM_ACK,
      output PIX_READY, MEM_REQ, MEM_ADDR, MEM_DATA
   );

   modport master (
      output PIX_VALID, X_IN, Y_IN, LINE_DONE, MEM_ACK,
      input  PIX_READY, MEM_REQ, MEM_ADDR, MEM_DATA
   );

endinterface

// File: rtl/pix_fifo.sv
// Small synchronous FIFO of pending pixel writes. Full/empty come straight
// from the registered pointers; flush discards every entry in one cycle.
module pix_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned    PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer MSB tells a full ring from an empty one
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = din;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/pixel_plotter.sv
// Consumer end of the line-rasterizer pixel stream: clips (x,y), converts to
// a linear address and writes the latched colour to video RAM via a FIFO.
module pixel_plotter #(
   parameter int unsigned FB_W       = pixel_pkg::FB_W,
   parameter int unsigned FB_H       = pixel_pkg::FB_H,
   parameter int unsigned COORD_W    = pixel_pkg::COORD_W,
   parameter int unsigned ADDR_W     = pixel_pkg::ADDR_W,
   parameter int unsigned COLOR_W    = pixel_pkg::COLOR_W,
   parameter int unsigned FIFO_DEPTH = pixel_pkg::FIFO_DEPTH
) (
   input  logic               ACLK,
   input  logic               ARST,
   input  logic               EN,
   input  logic [COLOR_W-1:0] COLOR,
   pixel_plotter_if.slave     bus,
   output logic               BUSY,
   output logic               DONE,
   output logic [15:0]        PIX_COUNT,
   output logic [15:0]        CLIP_COUNT
);

   import pixel_pkg::*;

   localparam int unsigned ENTRY_W = ADDR_W + COLOR_W;

   plot_state_t        state_q, state_d;
   logic               abort_q, abort_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic [15:0]        pix_cnt_q, pix_cnt_d;
   logic [15:0]        clip_cnt_q, clip_cnt_d;

   logic [COORD_W-1:0] x_in, y_in;
   logic               in_range, pix_ready, accept, mem_req;
   logic [ADDR_W-1:0]  pix_addr;
   logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_din, fifo_dout;

   assign x_in     = bus.X_IN;
   assign y_in     = bus.Y_IN;
   assign in_range = (32'(x_in) < FB_W) && (32'(y_in) < FB_H);
   assign pix_addr = ADDR_W'(xy_to_addr(32'(x_in), 32'(y_in), FB_W));
   assign fifo_din = {pix_addr, color_q};

   always_comb begin
      state_d    = state_q;
      abort_d    = abort_q;
      color_d    = color_q;
      pix_cnt_d  = pix_cnt_q;
      clip_cnt_d = clip_cnt_q;
      fifo_flush = 1'b0;

      pix_ready = EN && (state_q == RUN) && !abort_q && !fifo_full;
      accept    = bus.PIX_VALID && pix_ready;
      fifo_push = accept && in_range;
      mem_req   = !fifo_empty;
      fifo_pop  = mem_req && bus.MEM_ACK;

      if (fifo_pop && (pix_cnt_q != '1)) pix_cnt_d = pix_cnt_q + 16'd1;
      if (accept && !in_range && (clip_cnt_q != '1)) clip_cnt_d = clip_cnt_q + 16'd1;

      unique case (state_q)
         IDLE: begin
            if (EN) begin
               state_d    = RUN;
               abort_d    = 1'b0;
               color_d    = COLOR;
               pix_cnt_d  = '0;
               clip_cnt_d = '0;
            end
         end
         RUN, DRAIN: begin
            // Abort is sticky: the in-flight head must still see its ACK,
            // then everything behind it is discarded unwritten.
            if (!EN || abort_q) begin
               abort_d = 1'b1;
               if (fifo_empty || fifo_pop) begin
                  fifo_flush = 1'b1;
                  abort_d    = 1'b0;
                  state_d    = IDLE;
               end
            end else if (state_q == RUN) begin
               if (bus.LINE_DONE) state_d = DRAIN;
            end else if (fifo_empty && !mem_req) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            if (!EN) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (ACLK),
      .rst   (ARST),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         state_q    <= IDLE;
         abort_q    <= 1'b0;
         color_q    <= '0;
         pix_cnt_q  <= '0;
         clip_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         abort_q    <= abort_d;
         color_q    <= color_d;
         pix_cnt_q  <= pix_cnt_d;
         clip_cnt_q <= clip_cnt_d;
      end
   end

   assign bus.PIX_READY = pix_ready;
   assign bus.MEM_REQ   = mem_req;
   assign bus.MEM_ADDR  = mem_req ? fifo_dout[ENTRY_W-1:COLOR_W] : '0;
   assign bus.MEM_DATA  = mem_req ? fifo_dout[COLOR_W-1:0] : '0;
   assign BUSY          = (state_q != IDLE);
   assign DONE          = (state_q == FINISH);
   assign PIX_COUNT     = pix_cnt_q;
   assign CLIP_COUNT    = clip_cnt_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Self-checking bench for pixel_plotter: expected writes are queued when a
// pixel is accepted and compared in order when the memory port retires them.
module tb_pixel_plotter;

   typedef struct packed {
      logic [14:0] addr;
      logic [2:0]  data;
   } wr_t;

   logic        ACLK = 1'b0;
   logic        ARST = 1'b1;
   logic        EN = 1'b0;
   logic [2:0]  COLOR = '0;
   logic        BUSY, DONE;
   logic [15:0] PIX_COUNT, CLIP_COUNT;

   pixel_plotter_if #(.COORD_W(8), .ADDR_W(15), .COLOR_W(3)) bus ();

   pixel_plotter #(
      .FB_W       (160),
      .FB_H       (120),
      .COORD_W    (8),
      .ADDR_W     (15),
      .COLOR_W    (3),
      .FIFO_DEPTH (4)
   ) dut (
      .ACLK       (ACLK),
      .ARST       (ARST),
      .EN         (EN),
      .COLOR      (COLOR),
      .bus        (bus),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .PIX_COUNT  (PIX_COUNT),
      .CLIP_COUNT (CLIP_COUNT)
   );

   always #5 ACLK = ~ACLK;

   wr_t        sb[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         writes = 0;
   int         accepted = 0;
   int         exp_clip = 0;
   bit         done_seen = 1'b0;
   logic [2:0] cur_color = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Retired writes are compared against the head of the scoreboard
   always @(negedge ACLK) begin
      if (DONE) done_seen = 1'b1;
      if (bus.MEM_REQ && bus.MEM_ACK) begin
         writes++;
         if (sb.size() == 0) begin
            check_eq("write_unexpected", 32'(bus.MEM_REQ), 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check_eq("wr_addr", 32'(bus.MEM_ADDR), 32'(e.addr));
            check_eq("wr_data", 32'(bus.MEM_DATA), 32'(e.data));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   task automatic start_line(input logic [2:0] c, input logic ack);
      COLOR       = c;
      cur_color   = c;
      bus.MEM_ACK = ack;
      exp_clip    = 0;
      EN          = 1'b1;
   endtask

   task automatic send_pixel(input int x, input int y, input bit last);
      int  n;
      wr_t e;
      n = 0;
      bus.X_IN      = 8'(x);
      bus.Y_IN      = 8'(y);
      bus.PIX_VALID = 1'b1;
      forever begin
         @(negedge ACLK);
         if (bus.PIX_READY) break;
         n++;
         if (n > 200) break;
      end
      check_eq("pix_accept", 32'(bus.PIX_READY), 32'd1);
      if (bus.PIX_READY) begin
         if (last) bus.LINE_DONE = 1'b1;
         accepted++;
         if (x < 160 && y < 120) begin
            e.addr = 15'(y * 160 + x);
            e.data = cur_color;
            sb.push_back(e);
         end else begin
            exp_clip++;
         end
      end
      @(posedge ACLK);
      #1;
      bus.PIX_VALID = 1'b0;
      bus.LINE_DONE = 1'b0;
   endtask

   task automatic pulse_line_done();
      bus.LINE_DONE = 1'b1;
      cycles(1);
      bus.LINE_DONE = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!DONE && n < 500) begin
         cycles(1);
         n++;
      end
      check_eq("done_reached", 32'(DONE), 32'd1);
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!bus.MEM_REQ && n < 50) begin
         cycles(1);
         n++;
      end
      check_eq("req_seen", 32'(bus.MEM_REQ), 32'd1);
   endtask

   task automatic end_line();
      EN = 1'b0;
      cycles(1);
      check_eq("end_done_low", 32'(DONE), 32'd0);
      check_eq("end_idle", 32'(BUSY), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   wr0;
      int   changes;
      logic [14:0] first_addr;

      bus.PIX_VALID = 1'b0;
      bus.LINE_DONE = 1'b0;
      bus.MEM_ACK   = 1'b0;
      bus.X_IN      = '0;
      bus.Y_IN      = '0;

      // Reset state
      cycles(3);
      check_eq("rst_busy", 32'(BUSY), 32'd0);
      check_eq("rst_done", 32'(DONE), 32'd0);
      check_eq("rst_req", 32'(bus.MEM_REQ), 32'd0);
      check_eq("rst_ready", 32'(bus.PIX_READY), 32'd0);
      check_eq("rst_pix", 32'(PIX_COUNT), 32'd0);
      check_eq("rst_clip", 32'(CLIP_COUNT), 32'd0);
      ARST = 1'b0;
      cycles(2);
      check_eq("idle_busy", 32'(BUSY), 32'd0);

      // 1: corner pixels, ACK tied high, separate LINE_DONE pulse
      start_line(3'd5, 1'b1);
      send_pixel(0, 0, 1'b0);
      send_pixel(159, 119, 1'b0);
      send_pixel(10, 2, 1'b0);
      pulse_line_done();
      wait_done();
      check_eq("t1_pix", 32'(PIX_COUNT), 32'd3);
      check_eq("t1_sb_empty", 32'(sb.size()), 32'd0);
      cycles(5);
      check_eq("t1_done_hold", 32'(DONE), 32'd1);
      check_eq("t1_busy_hold", 32'(BUSY), 32'd1);
      end_line();
      cycles(2);
      check_eq("t1_no_restart", 32'(BUSY), 32'd0);

      // 2: clipping
      start_line(3'd2, 1'b1);
      send_pixel(160, 0, 1'b0);
      send_pixel(0, 120, 1'b0);
      send_pixel(255, 255, 1'b0);
      send_pixel(3, 3, 1'b0);
      pulse_line_done();
      wait_done();
      check_eq("t2_clip", 32'(CLIP_COUNT), 32'(exp_clip));
      check_eq("t2_clip_abs", 32'(CLIP_COUNT), 32'd3);
      check_eq("t2_pix", 32'(PIX_COUNT), 32'd1);
      check_eq("t2_sb_empty", 32'(sb.size()), 32'd0);
      end_line();

      // 3: memory stall with FIFO back-pressure
      accepted = 0;
      start_line(3'd6, 1'b0);
      fork
         begin
            for (int i = 1; i <= 6; i++) send_pixel(i, 1, 1'b0);
            pulse_line_done();
         end
         begin
            wait_req();
            first_addr = bus.MEM_ADDR;
            changes = 0;
            repeat (20) begin
               @(negedge ACLK);
               if (bus.MEM_ADDR !== first_addr) changes++;
            end
            check_eq("t3_first_addr", 32'(first_addr), 32'd161);
            check_eq("t3_addr_stable", 32'(changes), 32'd0);
            check_eq("t3_ready_low", 32'(bus.PIX_READY), 32'd0);
            check_eq("t3_accepted", 32'(accepted), 32'd4);
            @(posedge ACLK);
            #1;
            bus.MEM_ACK = 1'b1;
         end
      join
      wait_done();
      check_eq("t3_pix", 32'(PIX_COUNT), 32'd6);
      check_eq("t3_sb_empty", 32'(sb.size()), 32'd0);
      end_line();

      // 4: LINE_DONE together with the last pixel
      start_line(3'd4, 1'b0);
      send_pixel(20, 5, 1'b0);
      send_pixel(7, 7, 1'b1);
      cycles(3);
      check_eq("t4_done_early", 32'(DONE), 32'd0);
      check_eq("t4_busy", 32'(BUSY), 32'd1);
      check_eq("t4_req", 32'(bus.MEM_REQ), 32'd1);
      bus.MEM_ACK = 1'b1;
      wait_done();
      check_eq("t4_pix", 32'(PIX_COUNT), 32'd2);
      check_eq("t4_sb_empty", 32'(sb.size()), 32'd0);
      end_line();

      // 5: abort with three writes pending
      done_seen = 1'b0;
      start_line(3'd3, 1'b0);
      wr0 = writes;
      send_pixel(1, 0, 1'b0);
      send_pixel(2, 0, 1'b0);
      send_pixel(3, 0, 1'b0);
      cycles(2);
      EN = 1'b0;
      cycles(2);
      check_eq("t5_busy_wait", 32'(BUSY), 32'd1);
      check_eq("t5_req_head", 32'(bus.MEM_REQ), 32'd1);
      check_eq("t5_head_addr", 32'(bus.MEM_ADDR), 32'd1);
      bus.MEM_ACK = 1'b1;
      cycles(4);
      check_eq("t5_one_write", 32'(writes - wr0), 32'd1);
      check_eq("t5_req_off", 32'(bus.MEM_REQ), 32'd0);
      check_eq("t5_idle", 32'(BUSY), 32'd0);
      check_eq("t5_pix", 32'(PIX_COUNT), 32'd1);
      check_eq("t5_no_done", 32'(done_seen), 32'd0);
      sb.delete();

      // 6: asynchronous reset during a pending write
      start_line(3'd6, 1'b1);
      send_pixel(8, 8, 1'b0);
      send_pixel(200, 0, 1'b0);
      cycles(2);
      bus.MEM_ACK = 1'b0;
      send_pixel(9, 9, 1'b0);
      wait_req();
      check_eq("t6_pix_pre", 32'(PIX_COUNT), 32'd1);
      check_eq("t6_clip_pre", 32'(CLIP_COUNT), 32'd1);
      #3;
      ARST = 1'b1;
      #1;
      check_eq("t6_req", 32'(bus.MEM_REQ), 32'd0);
      check_eq("t6_addr", 32'(bus.MEM_ADDR), 32'd0);
      check_eq("t6_data", 32'(bus.MEM_DATA), 32'd0);
      check_eq("t6_busy", 32'(BUSY), 32'd0);
      check_eq("t6_ready", 32'(bus.PIX_READY), 32'd0);
      check_eq("t6_pix", 32'(PIX_COUNT), 32'd0);
      check_eq("t6_clip", 32'(CLIP_COUNT), 32'd0);
      sb.delete();
      EN = 1'b0;
      cycles(1);
      ARST = 1'b0;
      cycles(1);
      start_line(3'd1, 1'b1);
      send_pixel(0, 1, 1'b1);
      wait_done();
      check_eq("t6_new_pix", 32'(PIX_COUNT), 32'd1);
      check_eq("t6_new_clip", 32'(CLIP_COUNT), 32'd0);
      check_eq("t6_sb_empty", 32'(sb.size()), 32'd0);
      end_line();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
